// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared constants and types for the immediate-generator pipeline.
//   - RISC-V major opcodes recognised by the decoder
//   - shift-immediate upper-bit patterns that mark an encoding as legal
//   - fmt_e: output format code, skid_state_e: skid-buffer occupancy
package imm_gen_pkg;

    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOpImm32 = 7'b0011011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcOp      = 7'b0110011;

    // Non-zero upper-bit patterns accepted for shifts (arithmetic right shift).
    localparam logic [5:0] ShUpper6Alt = 6'b010000;
    localparam logic [6:0] ShUpper7Alt = 7'b0100000;

    typedef enum logic [2:0] {
        FmtR    = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtSh   = 3'd6,
        FmtNone = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational RISC-V immediate decoder.
//   instr   - raw 32-bit instruction word
//   imm     - decoded immediate, sign- or zero-extended to XLEN
//   fmt     - format code (fmt_e)
//   illegal - unknown opcode or reserved shift encoding
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter bit          RV64 = (XLEN == 64)
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_shift;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3 == 3'd1) || (funct3 == 3'd5);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    always_comb begin
        imm     = '0;
        fmt     = FmtNone;
        illegal = 1'b0;
        case (opcode)
            OpcLui, OpcAuipc: begin
                fmt = FmtU;
                imm = sext32({instr[31:12], 12'b0});
            end
            OpcJal: begin
                fmt = FmtJ;
                imm = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0});
            end
            OpcJalr, OpcLoad: begin
                fmt = FmtI;
                imm = sext32({{20{instr[31]}}, instr[31:20]});
            end
            OpcOpImm: begin
                if (is_shift) begin
                    fmt = FmtSh;
                    if (RV64) begin
                        imm     = XLEN'(instr[25:20]);
                        illegal = !((instr[31:26] == 6'b0) || (instr[31:26] == ShUpper6Alt));
                    end else begin
                        imm     = XLEN'(instr[24:20]);
                        illegal = !((instr[31:25] == 7'b0) || (instr[31:25] == ShUpper7Alt));
                    end
                end else begin
                    fmt = FmtI;
                    imm = sext32({{20{instr[31]}}, instr[31:20]});
                end
            end
            OpcOpImm32: begin
                if (!RV64) begin
                    illegal = 1'b1;
                end else if (is_shift) begin
                    // Word shifts always use a 5-bit shamt, even on RV64.
                    fmt     = FmtSh;
                    imm     = XLEN'(instr[24:20]);
                    illegal = !((instr[31:25] == 7'b0) || (instr[31:25] == ShUpper7Alt));
                end else begin
                    fmt = FmtI;
                    imm = sext32({{20{instr[31]}}, instr[31:20]});
                end
            end
            OpcStore: begin
                fmt = FmtS;
                imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            end
            OpcBranch: begin
                fmt = FmtB;
                imm = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0});
            end
            OpcOp: begin
                fmt = FmtR;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate decoder followed by a 2-entry skid buffer.
//   clk, reset (sync, active-high), flush (drop all buffered entries)
//   in_valid/in_ready/in_instr   - input handshake, in_ready comes from a flop
//   out_valid/out_ready          - output handshake
//   out_imm/out_fmt/out_illegal  - decoded fields of the oldest (main) entry
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter bit          RV64 = (XLEN == 64)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    imm_decode #(
        .XLEN (XLEN),
        .RV64 (RV64)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    skid_state_e     state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    fmt_e            main_fmt_q, main_fmt_d, skid_fmt_q, skid_fmt_d;
    logic            main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
    logic            in_xfer, out_xfer;

    assign out_valid   = (state_q != StEmpty);
    assign in_ready    = in_ready_q;
    assign out_imm     = main_imm_q;
    assign out_fmt     = main_fmt_q;
    assign out_illegal = main_ill_q;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_fmt_d = main_fmt_q;
        main_ill_d = main_ill_q;
        skid_imm_d = skid_imm_q;
        skid_fmt_d = skid_fmt_q;
        skid_ill_d = skid_ill_q;
        case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d    = StOne;
                    main_imm_d = dec_imm;
                    main_fmt_d = dec_fmt;
                    main_ill_d = dec_illegal;
                end
            end
            StOne: begin
                if (in_xfer && out_xfer) begin
                    main_imm_d = dec_imm;
                    main_fmt_d = dec_fmt;
                    main_ill_d = dec_illegal;
                end else if (in_xfer) begin
                    state_d    = StTwo;
                    skid_imm_d = dec_imm;
                    skid_fmt_d = dec_fmt;
                    skid_ill_d = dec_illegal;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                // in_ready is low here, so only the drain side can move.
                if (out_xfer) begin
                    state_d    = StOne;
                    main_imm_d = skid_imm_q;
                    main_fmt_d = skid_fmt_q;
                    main_ill_d = skid_ill_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d = StEmpty;
        end
        in_ready_d = (state_d != StTwo);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
            main_imm_q <= '0;
            main_fmt_q <= FmtNone;
            main_ill_q <= 1'b0;
            skid_imm_q <= '0;
            skid_fmt_q <= FmtNone;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_imm_q <= main_imm_d;
            main_fmt_q <= main_fmt_d;
            main_ill_q <= main_ill_d;
            skid_imm_q <= skid_imm_d;
            skid_fmt_q <= skid_fmt_d;
            skid_ill_q <= skid_ill_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives an XLEN=32 and an XLEN=64 instance with identical stimulus and
// checks both against a queue-based reference model of the decoder and buffer.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;

    logic        rdy32, rdy64, ov32, ov64, ill32, ill64;
    logic [2:0]  fmt32, fmt64;
    logic [31:0] imm32;
    logic [63:0] imm64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (rdy32),
        .in_instr    (in_instr),
        .out_valid   (ov32),
        .out_ready   (out_ready),
        .out_imm     (imm32),
        .out_fmt     (fmt32),
        .out_illegal (ill32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (rdy64),
        .in_instr    (in_instr),
        .out_valid   (ov64),
        .out_ready   (out_ready),
        .out_imm     (imm64),
        .out_fmt     (fmt64),
        .out_illegal (ill64)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] q[$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: immediate as a 64-bit value; the 32-bit view is its low half.
    function automatic void ref_dec(input logic [31:0] i, input bit rv64,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        logic [6:0] op;
        logic [2:0] f3;
        bit         sh;
        op  = i[6:0];
        f3  = i[14:12];
        sh  = (f3 == 3'd1) || (f3 == 3'd5);
        imm = 64'd0;
        fmt = 3'd7;
        ill = 1'b0;
        case (op)
            7'b0110111, 7'b0010111: begin
                fmt = 3'd4; imm = 64'($signed({i[31:12], 12'h000}));
            end
            7'b1101111: begin
                fmt = 3'd5; imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            7'b1100111, 7'b0000011: begin
                fmt = 3'd1; imm = 64'($signed(i[31:20]));
            end
            7'b0010011: begin
                if (sh && rv64) begin
                    fmt = 3'd6; imm = 64'(i[25:20]);
                    ill = !(i[31:26] == 6'd0 || i[31:26] == 6'b010000);
                end else if (sh) begin
                    fmt = 3'd6; imm = 64'(i[24:20]);
                    ill = !(i[31:25] == 7'd0 || i[31:25] == 7'b0100000);
                end else begin
                    fmt = 3'd1; imm = 64'($signed(i[31:20]));
                end
            end
            7'b0011011: begin
                if (!rv64) begin
                    ill = 1'b1;
                end else if (sh) begin
                    fmt = 3'd6; imm = 64'(i[24:20]);
                    ill = !(i[31:25] == 7'd0 || i[31:25] == 7'b0100000);
                end else begin
                    fmt = 3'd1; imm = 64'($signed(i[31:20]));
                end
            end
            7'b0100011: begin
                fmt = 3'd2; imm = 64'($signed({i[31:25], i[11:7]}));
            end
            7'b1100011: begin
                fmt = 3'd3; imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            7'b0110011: fmt = 3'd0;
            default:    ill = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0:  w[6:0] = 7'b0110111;
            1:  w[6:0] = 7'b0010111;
            2:  w[6:0] = 7'b1101111;
            3:  w[6:0] = 7'b1100111;
            4:  w[6:0] = 7'b0000011;
            5, 6: w[6:0] = 7'b0010011;
            7:  w[6:0] = 7'b0011011;
            8:  w[6:0] = 7'b0100011;
            9:  w[6:0] = 7'b1100011;
            10: w[6:0] = 7'b0110011;
            default: ;
        endcase
        if (w[6:0] == 7'b0010011 || w[6:0] == 7'b0011011) begin
            if ($urandom_range(0, 1) == 1) w[14:12] = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
            case ($urandom_range(0, 2))
                0: w[31:26] = 6'd0;
                1: w[31:26] = 6'b010000;
                default: ;
            endcase
        end
        return w;
    endfunction

    // Buffer model: an ordered queue of accepted instructions, at most two deep.
    always @(posedge clk) begin
        if (reset || flush) begin
            q.delete();
        end else begin
            automatic bit acc = in_valid && (q.size() < 2);
            automatic bit pop = out_ready && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(in_instr);
        end
    end

    logic [63:0] m_imm32, m_imm64;
    logic [2:0]  m_fmt32, m_fmt64;
    logic        m_ill32, m_ill64;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            ref_dec(q[0], 1'b0, m_imm32, m_fmt32, m_ill32);
            ref_dec(q[0], 1'b1, m_imm64, m_fmt64, m_ill64);
            chk("pipe32", {ov32, rdy32, fmt32, ill32, imm32},
                {1'b1, q.size() < 2, m_fmt32, m_ill32, m_imm32[31:0]});
            chk("pipe64", {ov64, rdy64, fmt64, ill64, imm64},
                {1'b1, q.size() < 2, m_fmt64, m_ill64, m_imm64});
        end else begin
            chk("idle32", {ov32, rdy32}, 2'b01);
            chk("idle64", {ov64, rdy64}, 2'b01);
        end
    end

    logic [63:0] p_imm;
    logic [2:0]  p_fmt;
    logic        p_ill;
    logic [31:0] dw[6];

    initial begin
        repeat (3) @(negedge clk);
        chk("reset32", {ov32, rdy32, imm32, fmt32, ill32}, {1'b0, 1'b1, 32'h0, 3'd7, 1'b0});
        chk("reset64", {ov64, rdy64, imm64, fmt64, ill64}, {1'b0, 1'b1, 64'h0, 3'd7, 1'b0});
        reset = 1'b0;

        // Pin the reference model with hand-decoded words.
        ref_dec(32'hFFF00093, 1'b0, p_imm, p_fmt, p_ill);
        chk("pin_i", {p_imm, p_fmt, p_ill}, {64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0});
        ref_dec(32'hFE112E23, 1'b0, p_imm, p_fmt, p_ill);
        chk("pin_s", {p_imm, p_fmt, p_ill}, {64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0});
        ref_dec(32'hFE000CE3, 1'b0, p_imm, p_fmt, p_ill);
        chk("pin_b", {p_imm, p_fmt, p_ill}, {64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0});
        ref_dec(32'h0010006F, 1'b0, p_imm, p_fmt, p_ill);
        chk("pin_j", {p_imm, p_fmt, p_ill}, {64'h800, 3'd5, 1'b0});
        ref_dec(32'h01F09093, 1'b0, p_imm, p_fmt, p_ill);
        chk("pin_sh", {p_imm, p_fmt, p_ill}, {64'h1F, 3'd6, 1'b0});
        ref_dec(32'h4200D093, 1'b0, p_imm, p_fmt, p_ill);
        chk("pin_sh32_ill", {p_fmt, p_ill}, {3'd6, 1'b1});
        ref_dec(32'h4200D093, 1'b1, p_imm, p_fmt, p_ill);
        chk("pin_sh64", {p_imm, p_fmt, p_ill}, {64'd32, 3'd6, 1'b0});
        ref_dec(32'h800000B7, 1'b1, p_imm, p_fmt, p_ill);
        chk("pin_u64", {p_imm, p_fmt, p_ill}, {64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0});
        ref_dec(32'h0000007F, 1'b1, p_imm, p_fmt, p_ill);
        chk("pin_none", {p_imm, p_fmt, p_ill}, {64'h0, 3'd7, 1'b1});
        ref_dec(32'h0000001B, 1'b0, p_imm, p_fmt, p_ill);
        chk("pin_opimm32_rv32", {p_imm, p_fmt, p_ill}, {64'h0, 3'd7, 1'b1});

        // Back-to-back I then S with the consumer always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        @(negedge clk);
        chk("b2b_first", {ov32, imm32, fmt32}, {1'b1, 32'hFFFF_FFFF, 3'd1});
        in_instr = 32'hFE112E23;
        @(negedge clk);
        chk("b2b_second", {ov32, imm32, fmt32}, {1'b1, 32'hFFFF_FFFC, 3'd2});
        in_valid = 1'b0;
        @(negedge clk);

        dw = '{32'hFE000CE3, 32'h0010006F, 32'h01F09093, 32'h4200D093, 32'h800000B7,
               32'h0000007F};
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_instr = dw[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Back-pressure: three offered, two held, order kept on release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        @(negedge clk);
        chk("bp_one", {ov32, rdy32}, 2'b11);
        in_instr = 32'h01F09093;
        @(negedge clk);
        chk("bp_two", {ov32, rdy32, imm32}, {1'b1, 1'b0, 32'hFFFF_FFFF});
        in_instr = 32'h0010006F;
        @(negedge clk);
        chk("bp_hold", {ov32, rdy32, imm32}, {1'b1, 1'b0, 32'hFFFF_FFFF});
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second_out", {ov32, imm32, fmt32}, {1'b1, 32'h1F, 3'd6});
        @(negedge clk);
        chk("bp_drained", {ov32, rdy32}, 2'b01);

        // Flush, then reset, each with a full buffer and a simultaneous input.
        for (int r = 0; r < 2; r++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_instr  = 32'hFFF00093;
            @(negedge clk);
            in_instr = 32'hFE112E23;
            @(negedge clk);
            if (r == 0) flush = 1'b1;
            else        reset = 1'b1;
            in_instr = 32'h0010006F;
            @(negedge clk);
            chk(r == 0 ? "flush_now" : "reset_now", {ov32, rdy32, ov64, rdy64}, 4'b0101);
            flush    = 1'b0;
            reset    = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            chk(r == 0 ? "flush_after" : "reset_after", {ov32, ov64}, 2'b00);
        end

        // Streaming at full rate.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (60) begin
            in_instr = rand_instr();
            @(negedge clk);
        end

        // Random traffic with occasional flush and reset.
        repeat (3000) begin
            reset     = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_instr  = rand_instr();
            @(negedge clk);
        end
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the immediate output width; legal values are 32 and 64.
REQ-002 Parameter RV64, default (XLEN==64), SHALL enable 6-bit shift amounts and the OP-IMM-32 opcode 0011011.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  in_instr is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_instr this cycle; driven directly from a flop.
REQ-008 in_instr  input  32  raw instruction word.
REQ-009 out_valid  output  1  out_* fields are valid.
REQ-010 out_ready  input  1  consumer accepts the out_* fields this cycle.
REQ-011 out_imm  output  XLEN  decoded immediate.
REQ-012 out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, SH=6, NONE=7.
REQ-013 out_illegal  output  1  opcode unknown or shift encoding reserved.

Function
REQ-014 Decode SHALL use opcode in_instr[6:0] and funct3 in_instr[14:12]; sext means sign-extend to XLEN.
REQ-015 LUI 0110111 / AUIPC 0010111 -> U: sext({i[31:12],12'b0}).
REQ-016 JAL 1101111 -> J: sext({i[31],i[19:12],i[20],i[30:21],1'b0}).
REQ-017 JALR 1100111, LOAD 0000011, OP-IMM 0010011 with funct3 not 1/5, and OP-IMM-32 (RV64 only) with funct3 not 1/5 -> I: sext(i[31:20]).
REQ-018 OP-IMM funct3 1/5 -> SH: zero-extended i[25:20] if RV64, else i[24:20]; OP-IMM-32 funct3 1/5 -> SH: zero-extended i[24:20].
REQ-019 SH legality: illegal unless the upper bits (i[31:26] if RV64 OP-IMM, else i[31:25]) equal all-zero or 0b010000 / 0b0100000.
REQ-020 STORE 0100011 -> S: sext({i[31:25],i[11:7]}); BRANCH 1100011 -> B: sext({i[31],i[7],i[30:25],i[11:8],1'b0}).
REQ-021 OP 0110011 -> R with imm 0; any other opcode, including 0011011 when not RV64 -> NONE, imm 0, out_illegal=1.
REQ-022 Decode SHALL be combinational on the input side; stored entries hold decoded results (imm, fmt, illegal).
REQ-023 Buffer: 2-entry skid (main + skid register), states EMPTY, ONE, TWO.
REQ-024 A transfer occurs on a side when valid&&ready are both high on that side at the clock edge.
REQ-025 EMPTY: input transfer -> ONE.
REQ-026 ONE: input only -> TWO; output only -> EMPTY; both or neither -> ONE.
REQ-027 TWO: output transfer -> ONE, with skid moving to main; input cannot transfer because in_ready=0.
REQ-028 in_ready SHALL be registered = (next state != TWO); out_valid = (state != EMPTY); out_* SHALL reflect the main entry.
REQ-029 Latency SHALL be 1 cycle from input transfer to out_valid when the buffer was empty; sustained throughput SHALL be 1 per cycle with out_ready high.
REQ-030 Ordering SHALL be strict FIFO; out_* SHALL be stable while out_valid && !out_ready.
REQ-031 flush SHALL force EMPTY next cycle and set in_ready=1; an input transfer in a flush cycle is discarded; flush overrides all other events.

Reset
REQ-032 While reset is high the block SHALL ignore in_valid and flush.
REQ-033 After reset: state EMPTY, out_valid=0, in_ready=1, out_imm=0, out_fmt=NONE(7), out_illegal=0.
REQ-034 Reset mid-operation SHALL drop both entries with no output transfer.

Structure
REQ-035 Package imm_gen_pkg SHALL hold the opcode constants, the fmt enum and the SH upper-bit patterns.
REQ-036 Sub-module imm_decode (combinational, parameter XLEN/RV64) SHALL perform REQ-014..021; imm_gen_pipe SHALL instantiate it once and own the skid buffer.

Verification
REQ-037 XLEN=32: 0xFFF00093 then 0xFE112E23, out_ready=1 -> imm 0xFFFFFFFF fmt I, then 0xFFFFFFFC fmt S, on consecutive cycles.
REQ-038 XLEN=32: 0xFE000CE3 -> 0xFFFFFFF8 fmt B; 0x0010006F -> 0x00000800 fmt J; 0x01F09093 -> 0x0000001F fmt SH.
REQ-039 0x4200D093: XLEN=32 -> out_illegal=1; XLEN=64 -> SH with imm 32, out_illegal=0.
REQ-040 XLEN=64: 0x800000B7 -> 0xFFFFFFFF80000000 fmt U; opcode 0x7F -> NONE, imm 0, out_illegal=1.
REQ-041 out_ready=0, 3 inputs offered -> 2 accepted, in_ready falls the cycle after the 2nd; release -> order preserved, no loss or duplication.
REQ-042 flush and reset asserted with TWO entries plus a simultaneous input -> next cycle out_valid=0, in_ready=1, no entry emitted.
